fifo_word_packer: RTL and testbench
===================================

Name: fifo_word_packer

Overview:
- Downstream consumer of the `fifo` block.
- Pops WIDTH-bit entries through the FIFO's active-low read strobe and packs LANES consecutive entries into one wide word.
- Presents each word on a valid/ready output port.
- A flush request forces out a partial word with a lane-keep mask, so trailing data is never stranded.

Parameters:
- WIDTH, 8: entry width; must equal the upstream `fifo` WIDTH.
- LANES, 4: entries per output word; legal range 2..16.

Ports:
- clk  input  1  single clock, shared with the upstream `fifo`.
- reset_n  input  1  synchronous, active-low reset.
- fifo_empty  input  1  `empty` flag from the upstream `fifo`.
- fifo_rd_n  output  1  active-low read strobe to the upstream `fifo`.
- fifo_dout  input  WIDTH  `dout` from the upstream `fifo`.
- out_data  output  WIDTH*LANES  packed word; lane k = bits [k*WIDTH +: WIDTH].
- out_keep  output  LANES  lane k holds valid data.
- out_valid  output  1  word available.
- out_ready  input  1  downstream accepts the word.
- flush  input  1  single-cycle pulse requesting emission of the partial word.
- busy  output  1  high when count!=0, a pop is pending, a flush is pending, or out_valid is high.

Behaviour:
- Reset: sampled on the rising edge of clk while reset_n=0. Clears:
  - fifo_rd_n=1, out_valid=0, out_keep=0, out_data=0, busy=0.
  - count=0, rd_pend=0, flush_req=0, state=FILL.
  - Reset mid-word or mid-pop discards all held data and any pending capture.
- FIFO read timing:
  - fifo_rd_n low in cycle t pops at edge t.
  - fifo_dout is valid during cycle t+1 and is captured at edge t+1.
  - rd_pend marks an outstanding capture.
- Pop rule (combinational): fifo_rd_n = ~(state==FILL & ~fifo_empty & ~flush_req & (count + rd_pend < LANES)).
  - No pop is ever issued while fifo_empty=1.
  - No over-read beyond LANES.
- Back-to-back pops are allowed: one entry per cycle sustained while the FIFO is non-empty.
- Lane fill order: the first entry captured goes to lane 0. Captured data lands in lane[count], then count increments.
- State FILL:
  - When a capture makes count==LANES: go to HOLD at that edge, out_valid=1, out_keep all ones.
  - When flush_req=1, rd_pend=0 and count>0: go to HOLD, out_keep = low `count` bits set. Unfilled lanes of out_data are 0.
  - When flush_req=1, rd_pend=0 and count==0: clear flush_req, no output.
- State HOLD:
  - out_data, out_keep and out_valid are stable until out_ready=1.
  - On the handshake edge (out_valid & out_ready): out_valid=0, count=0, out_data=0, flush_req=0, return to FILL.
  - No pops are issued in HOLD, so one bubble cycle occurs per word.
- Flush:
  - flush is latched into sticky flush_req. Further pulses while flush_req=1 have no extra effect.
  - A flush arriving with rd_pend=1 waits for that capture to complete, then emits.
  - If that capture fills the word, the full word satisfies the flush; no extra empty word is emitted.
  - A flush seen while in HOLD is satisfied by the current word.
- Minimum latency: from first pop to out_valid is LANES+1 cycles with a continuously non-empty FIFO.
- Widths: count is $clog2(LANES+1) bits. No arithmetic wrap is possible because of the pop rule.

Optional Feature:
- Macro: FIFO_WORD_PACKER_PARITY_EN.
- Defined:
  - Adds output out_parity [LANES-1:0].
  - Bit k = even parity (XOR reduction) of lane k, computed on capture and registered alongside out_data.
  - Lanes with keep=0 have parity 0.
  - Reset value 0; stable during HOLD.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Reset then full word: push 8'h11,22,33,44 into FIFO, out_ready=1 → out_data=32'h44332211, out_keep=4'hF, out_valid high one cycle; LANES+1 cycles after first fifo_rd_n low.
- Back-pressure: 8 entries 8'h01..08, out_ready=0 for 10 cycles → out_data=32'h04030201 held stable, fifo_rd_n stays 1. Release ready → second word 32'h08070605 follows.
- Flush partial: push 8'hA1,A2 then flush pulse → out_data=32'h0000A2A1, out_keep=4'b0011; busy=0 after handshake.
- Flush on empty: count=0, FIFO empty, pulse flush → no out_valid, busy returns 0 the next cycle.
- Flush during pending pop: flush in the same cycle as the 4th pop → single word with keep=4'hF, no trailing empty word.
- Mid-word reset: 3 entries captured, reset_n=0 for 2 cycles → out_valid=0, out_keep=0, fifo_rd_n=1. Next 4 entries produce a clean fresh word. With FIFO_WORD_PACKER_PARITY_EN, word 8'h01,03,07,FF → out_parity=4'b0101.

Source files
------------

// File: rtl/fifo_word_packer.sv
// Pops WIDTH-bit entries from an upstream fifo and packs LANES of them into one wide valid/ready word.
// Optional per-lane even-parity output is enabled by defining FIFO_WORD_PACKER_PARITY_EN.
module fifo_word_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_n,
  input  logic [WIDTH-1:0]         fifo_dout,
  output logic [WIDTH*LANES-1:0]   out_data,
  output logic [LANES-1:0]         out_keep,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic                     busy
`ifdef FIFO_WORD_PACKER_PARITY_EN
  ,
  output logic [LANES-1:0]         out_parity
`endif
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW:0]   LANES_L = (CW + 1)'(LANES);
  localparam logic [CW-1:0] LAST_L  = CW'(LANES - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state, next_state;
  logic [CW-1:0] count;
  logic          rd_pend;
  logic          flush_req;
  logic [CW:0]   fill_lvl;
  logic          pop, capture, last_cap, flush_go, handshake;

  function automatic logic [LANES-1:0] keep_mask(input logic [CW-1:0] n);
    logic [LANES-1:0] m;
    for (int k = 0; k < LANES; k++) m[k] = (CW'(k) < n);
    return m;
  endfunction

`ifdef FIFO_WORD_PACKER_PARITY_EN
  function automatic logic lane_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  always_comb begin
    next_state = state;
    fill_lvl   = {1'b0, count} + {{CW{1'b0}}, rd_pend};
    handshake  = out_valid & out_ready;
    capture    = (state == FILL) & rd_pend;
    last_cap   = capture & (count == LAST_L);
    flush_go   = (state == FILL) & flush_req & ~rd_pend;
    // Entries already in flight count against the word so we never over-read.
    pop        = reset_n & (state == FILL) & ~fifo_empty & ~flush_req & (fill_lvl < LANES_L);
    if (state == FILL) begin
      if (last_cap || (flush_go && (count != '0))) next_state = HOLD;
    end else begin
      if (handshake) next_state = FILL;
    end
  end

  assign fifo_rd_n = ~pop;
  assign busy      = (count != '0) | rd_pend | flush_req | out_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= FILL;
      count     <= '0;
      rd_pend   <= 1'b0;
      flush_req <= 1'b0;
      out_valid <= 1'b0;
      out_keep  <= '0;
      out_data  <= '0;
`ifdef FIFO_WORD_PACKER_PARITY_EN
      out_parity <= '0;
`endif
    end else begin
      state   <= next_state;
      rd_pend <= pop;
      if (state == FILL) begin
        if (capture) begin
          for (int k = 0; k < LANES; k++) begin
            if (CW'(k) == count) begin
              out_data[k*WIDTH +: WIDTH] <= fifo_dout;
`ifdef FIFO_WORD_PACKER_PARITY_EN
              out_parity[k] <= lane_parity(fifo_dout);
`endif
            end
          end
          count <= count + CW'(1);
        end
        // A word completed on this edge also satisfies any flush that arrives with it.
        if (last_cap) begin
          out_valid <= 1'b1;
          out_keep  <= '1;
        end else if (flush_go) begin
          if (count != '0) begin
            out_valid <= 1'b1;
            out_keep  <= keep_mask(count);
          end else begin
            flush_req <= 1'b0;
          end
        end else if (flush) begin
          flush_req <= 1'b1;
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
        out_keep  <= '0;
        out_data  <= '0;
        count     <= '0;
        flush_req <= 1'b0;
`ifdef FIFO_WORD_PACKER_PARITY_EN
        out_parity <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural upstream fifo, directed scenarios and a randomized packing run.
module tb_fifo_word_packer;

  logic        clk;
  logic        reset_n;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_n;
  logic [7:0]  fifo_dout;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic        busy;
`ifdef FIFO_WORD_PACKER_PARITY_EN
  logic [3:0]  out_parity;
`endif

  fifo_word_packer #(.WIDTH(8), .LANES(4)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_rd_n(fifo_rd_n),
    .fifo_dout(fifo_dout), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .busy(busy)
`ifdef FIFO_WORD_PACKER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream fifo: registered dout, empty flag updated on the clock edge.
  logic [7:0] push_data;
  logic       push_en = 1'b0;
  logic [7:0] fq[$];
  int         underflow = 0;
  always @(posedge clk) begin
    if (!fifo_rd_n) begin
      if (fq.size() == 0) underflow++;
      else fifo_dout <= fq.pop_front();
    end
    if (push_en) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
  end

  typedef struct {logic [31:0] d; logic [3:0] k; logic [3:0] p;} word_t;
  word_t      obs_q[$];
  logic [7:0] pend_q[$];
  int n_assert = 0, n_fail = 0;
  int cyc = 0, first_pop = -1, first_valid = -1, vcnt = 0;
  bit rand_push = 0, rand_ready = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cycle();
    word_t w;
    if (pend_q.size() > 0 && (!rand_push || $urandom_range(0, 2) != 0)) begin
      push_en = 1'b1;
      push_data = pend_q.pop_front();
    end else begin
      push_en = 1'b0;
    end
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    if (out_valid && out_ready) begin
      w.d = out_data;
      w.k = out_keep;
`ifdef FIFO_WORD_PACKER_PARITY_EN
      w.p = out_parity;
`else
      w.p = 4'h0;
`endif
      obs_q.push_back(w);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!fifo_rd_n && first_pop < 0) first_pop = cyc;
    if (out_valid) begin
      vcnt++;
      if (first_valid < 0) first_valid = cyc;
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    for (int i = 0; i < max && !out_valid; i++) cycle();
    chk(tag, out_valid, 1'b1);
  endtask

  // Reference: pack a byte list into LANES=4 words, last one partial with a keep mask.
  function automatic word_t ref_word(input logic [7:0] v[$], input int base);
    word_t w;
    w.d = '0; w.k = '0; w.p = '0;
    for (int j = 0; j < 4 && base + j < v.size(); j++) begin
      w.d = w.d | (32'(v[base + j]) << (8 * j));
      w.k[j] = 1'b1;
      w.p[j] = ^v[base + j];
    end
    return w;
  endfunction

  logic [7:0] rnd[$];
  word_t      ew;
  int         npops, vbefore;

  initial begin
    reset_n = 1'b0; out_ready = 1'b0; flush = 1'b0; push_data = '0;
    cycle(); cycle();
    chk("reset_rd_n", fifo_rd_n, 1'b1);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_keep", out_keep, 4'h0);
    chk("reset_data", out_data, 32'h0);
    chk("reset_busy", busy, 1'b0);
    reset_n = 1'b1;

    // Full word, latency and single-cycle valid
    out_ready = 1'b1; cyc = 0; first_pop = -1; first_valid = -1; vcnt = 0; obs_q.delete();
    pend_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (12) cycle();
    chk("full_count", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      chk("full_data", obs_q[0].d, 32'h44332211);
      chk("full_keep", obs_q[0].k, 4'hF);
    end
    chk("full_latency", first_valid - first_pop, 5);
    chk("full_valid_cycles", vcnt, 1);

    // Back-pressure
    out_ready = 1'b0; obs_q.delete();
    pend_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    wait_valid("bp_first_timeout", 30);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_data", out_data, 32'h04030201);
      chk("bp_hold_rd_n", fifo_rd_n, 1'b1);
      cycle();
    end
    chk("bp_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    cycle();
    wait_valid("bp_second_timeout", 20);
    chk("bp_second_data", out_data, 32'h08070605);
    chk("bp_second_keep", out_keep, 4'hF);
    cycle();
    chk("bp_words", obs_q.size(), 2);

    // Flush partial word
    out_ready = 1'b0;
    pend_q = '{8'hA1, 8'hA2};
    repeat (6) cycle();
    chk("fp_no_early_valid", out_valid, 1'b0);
    flush = 1'b1; cycle(); flush = 1'b0;
    wait_valid("fp_timeout", 10);
    chk("fp_data", out_data, 32'h0000A2A1);
    chk("fp_keep", out_keep, 4'b0011);
    out_ready = 1'b1; cycle();
    chk("fp_busy_after", busy, 1'b0);
    chk("fp_valid_after", out_valid, 1'b0);

    // Flush with nothing held
    repeat (2) cycle();
    vbefore = vcnt;
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("fe_busy_pending", busy, 1'b1);
    cycle();
    chk("fe_busy_clear", busy, 1'b0);
    repeat (4) cycle();
    chk("fe_no_valid", vcnt - vbefore, 0);

    // Flush alongside the fourth pop
    obs_q.delete(); npops = 0;
    pend_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int i = 0; i < 14; i++) begin
      if (!fifo_rd_n) npops++;
      flush = (!fifo_rd_n && npops == 4);
      cycle();
    end
    flush = 1'b0;
    chk("fpp_words", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      chk("fpp_data", obs_q[0].d, 32'hC4C3C2C1);
      chk("fpp_keep", obs_q[0].k, 4'hF);
    end
    chk("fpp_busy", busy, 1'b0);

    // Reset in the middle of a word
    out_ready = 1'b0;
    pend_q = '{8'hAA, 8'hBB, 8'hCC};
    repeat (6) cycle();
    reset_n = 1'b0; cycle(); cycle();
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_keep", out_keep, 4'h0);
    chk("mr_rd_n", fifo_rd_n, 1'b1);
    chk("mr_busy", busy, 1'b0);
    reset_n = 1'b1;
    pend_q = '{8'h01, 8'h03, 8'h07, 8'hFF};
    wait_valid("mr_timeout", 20);
    chk("mr_data", out_data, 32'hFF070301);
    chk("mr_keep_full", out_keep, 4'hF);
`ifdef FIFO_WORD_PACKER_PARITY_EN
    chk("mr_parity", out_parity, 4'b0101);
`endif
    out_ready = 1'b1; cycle(); cycle();

    // Randomized stream with random gaps and back-pressure, drained by a flush
    obs_q.delete(); rnd.delete();
    for (int i = 0; i < 23; i++) rnd.push_back(8'($urandom_range(0, 255)));
    pend_q = rnd;
    rand_push = 1; rand_ready = 1;
    for (int i = 0; i < 300 && pend_q.size() > 0; i++) cycle();
    repeat (30) cycle();
    flush = 1'b1; cycle(); flush = 1'b0;
    for (int i = 0; i < 60 && busy; i++) cycle();
    rand_push = 0; rand_ready = 0; out_ready = 1'b0;
    chk("rnd_idle", busy, 1'b0);
    chk("rnd_words", obs_q.size(), (rnd.size() + 3) / 4);
    for (int i = 0; i < obs_q.size() && i * 4 < rnd.size(); i++) begin
      ew = ref_word(rnd, i * 4);
      chk($sformatf("rnd_data_%0d", i), obs_q[i].d, ew.d);
      chk($sformatf("rnd_keep_%0d", i), obs_q[i].k, ew.k);
`ifdef FIFO_WORD_PACKER_PARITY_EN
      chk($sformatf("rnd_parity_%0d", i), obs_q[i].p, ew.p);
`endif
    end

    chk("no_underflow", underflow, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
